dm_lsu: RTL and testbench
=========================

Name: dm_lsu

Overview:
- Load/store sequencer; the initiator side of the data-memory interface. Drives dm_ctrl_sig, mem_ctrl_addr and data_in into data_mem, and captures data_out.
- Sits between the WWP execute/writeback stage and data_mem.
- Turns one processor request (load or store, base address, word count) into a burst of per-cycle memwld/memwst commands with auto-incrementing word addresses.
- Returns load data as a tagged stream.

Parameters:
- RD_LAT, 1: cycles from a memwld command on dm_ctrl to valid data on dm_data_out (1..4).
- LEN_W, 8: width of req_len.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request valid.
- req_ready, output, 1: block can accept a request (high only in IDLE).
- req_op, input, 1: 0 = load, 1 = store.
- req_addr, input, [0:31]: base word address.
- req_len, input, [0:LEN_W-1]: words in burst minus 1 (0 means 1 word, 255 means 256 words).
- wdata_valid, input, 1: store data word valid.
- wdata_ready, output, 1: store data accepted this cycle.
- wdata, input, [0:127]: store data word.
- rdata_valid, output, 1: load data word valid. No backpressure; the consumer must take it.
- rdata, output, [0:127]: load data word.
- rdata_last, output, 1: marks the final word of a load burst.
- busy, output, 1: block is not in IDLE.
- dm_ctrl, output, [0:1]: to data_mem dm_ctrl_sig.
- dm_addr, output, [0:31]: to data_mem mem_ctrl_addr.
- dm_data_in, output, [0:127]: to data_mem data_in.
- dm_data_out, input, [0:127]: from data_mem data_out.

Behaviour:
- Command encodings (shared definitions): memnop = 2'b00, memwld = 2'b01, memwst = 2'b10. Bit 0 is the MSB on every vector.
- Reset (low, asynchronous):
  - state = IDLE; dm_ctrl = memnop; dm_addr = 0; dm_data_in = 0.
  - rdata = 0; rdata_valid = 0; rdata_last = 0; busy = 0.
  - Load-tracking pipe cleared; any burst in progress is abandoned.
  - No rdata_valid is produced for commands issued before reset.
- All dm_* outputs and all rdata* outputs are registered.
- FSM states: IDLE, STORE, LOAD, DRAIN.
- IDLE:
  - req_ready = 1.
  - On req_valid at edge k: latch addr, remaining count = req_len, and op.
  - Go to STORE if req_op = 1, otherwise LOAD. dm_ctrl stays memnop.
- STORE:
  - wdata_ready = 1; it is 0 in every other state.
  - On each edge with wdata_valid = 1: dm_ctrl <= memwst, dm_addr <= cur_addr, dm_data_in <= wdata; then cur_addr + 1 and count - 1.
  - On each edge with wdata_valid = 0: dm_ctrl <= memnop and no address advance (gap tolerant).
  - After the word with count = 0 is taken, go to IDLE.
- LOAD:
  - Every cycle: dm_ctrl <= memwld, dm_addr <= cur_addr, cur_addr + 1, count - 1.
  - Push (valid = 1, last = (count == 0)) into an RD_LAT+1 deep shift pipe.
  - After the last issue, go to DRAIN; dm_ctrl <= memnop.
- DRAIN:
  - Wait until the pipe is empty, then go to IDLE.
  - req_ready stays 0 until the pipe is empty, so bursts never overlap.
- Load return:
  - When the pipe head is valid: rdata <= dm_data_out, rdata_valid <= 1, rdata_last <= head.last.
  - Word i of the burst (issued at command cycle c+i) appears as rdata_valid in cycle c+i+RD_LAT+1.
  - Otherwise rdata_valid = 0 and rdata holds its value.
- Latency:
  - Store: first memwst on dm_ctrl 2 cycles after request acceptance, given wdata_valid is already high.
  - Load: first rdata_valid RD_LAT+3 cycles after acceptance.
- Address wrap: 32'hFFFF_FFFF + 1 = 0, silently, with no error.
- busy = (state != IDLE).
- req_valid while busy is ignored; no queueing.
- wdata_valid outside STORE is ignored.

Optional Feature:
- Macro DM_LSU_STATS_EN defined adds:
  - Output ports ld_count [0:31] and st_count [0:31], both 0 on reset.
  - ld_count increments once per issued memwld; st_count once per issued memwst.
  - Both saturate at 32'hFFFF_FFFF.
- Macro not defined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dm_pkg holds:
  - memnop/memwld/memwst constants (consistent with control.h).
  - The FSM state encoding.
  - The 128-bit word width and 32-bit address width constants.
- One sub-module: dm_lsu_rdpipe.
  - An RD_LAT+1 deep valid/last shift register with an empty flag.
  - Instantiated once in dm_lsu.

Test Plan:
- Store burst: addr = 1, len = 8, wdata 128'h72..128'h7A continuous → dm_ctrl = memwst for 9 consecutive cycles, dm_addr 1..9, dm_data_in 72..7A, then memnop; req_ready back to 1.
- Load burst after store, RD_LAT = 1: addr = 1, len = 8 → 9 rdata_valid pulses with rdata 72..7A, rdata_last only on 7A, first pulse 4 cycles after acceptance.
- Store with wdata_valid gaps (pattern 1,0,0,1,1): dm_ctrl shows memwst,nop,nop,memwst,memwst; addresses 5,6,7; no skipped address.
- Wrap: load addr = 32'hFFFF_FFFE, len = 2 → dm_addr FFFF_FFFE, FFFF_FFFF, 0000_0000.
- Reset asserted low in LOAD after 3 issues → dm_ctrl = memnop and rdata_valid = 0 immediately; after release no rdata_valid appears; next request is accepted normally.
- DM_LSU_STATS_EN: the two bursts above → st_count = 9, ld_count = 9; an ignored req_valid while busy changes neither.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared data-memory command encodings, FSM state encoding and bus widths for dm_lsu.
package dm_pkg;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 128;

    localparam logic [0:1] memnop = 2'b00;
    localparam logic [0:1] memwld = 2'b01;
    localparam logic [0:1] memwst = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;
endpackage

// File: rtl/dm_lsu_rdpipe.sv
// Tracks in-flight memwld commands: DEPTH-deep valid/last shift register, head aligned with data_mem read data.
module dm_lsu_rdpipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_last,
    output logic head_vld,
    output logic head_last,
    output logic empty
);
    logic [0:DEPTH-1] vld_q;
    logic [0:DEPTH-1] last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= {push, vld_q[0:DEPTH-2]};
            last_q <= {push & push_last, last_q[0:DEPTH-2]};
        end
    end

    assign head_vld  = vld_q[DEPTH-1];
    assign head_last = last_q[DEPTH-1];
    assign empty     = ~|vld_q;
endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: turns one load/store request into a burst of memwld/memwst commands to data_mem; first memwst 2 cycles
// after accept, first load word RD_LAT+3 cycles after. Stores stall on wdata_valid; load returns have no backpressure.
// Optional DM_LSU_STATS_EN adds saturating ld_count/st_count outputs.
module dm_lsu
    import dm_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [0:ADDR_W-1] req_addr,
    input  logic [0:LEN_W-1]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [0:WORD_W-1] wdata,
    output logic              rdata_valid,
    output logic [0:WORD_W-1] rdata,
    output logic              rdata_last,
    output logic              busy,
`ifdef DM_LSU_STATS_EN
    output logic [0:31]       ld_count,
    output logic [0:31]       st_count,
`endif
    output logic [0:1]        dm_ctrl,
    output logic [0:ADDR_W-1] dm_addr,
    output logic [0:WORD_W-1] dm_data_in,
    input  logic [0:WORD_W-1] dm_data_out
);
    state_t             state, state_nxt;
    logic [0:ADDR_W-1]  cur_addr;
    logic [0:LEN_W-1]   count;
    logic               issue_ld, issue_st;
    logic               head_vld, head_last, pipe_empty;

    assign req_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign wdata_ready = (state == ST_STORE);
    assign issue_st    = (state == ST_STORE) && wdata_valid;
    assign issue_ld    = (state == ST_LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_valid) state_nxt = req_op ? ST_STORE : ST_LOAD;
            ST_STORE: if (wdata_valid && count == '0) state_nxt = ST_IDLE;
            ST_LOAD:  if (count == '0) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Address wraps silently at the top of the 32-bit space.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr   <= '0;
            count      <= '0;
            dm_ctrl    <= memnop;
            dm_addr    <= '0;
            dm_data_in <= '0;
        end else begin
            dm_ctrl <= memnop;
            if (state == ST_IDLE && req_valid) begin
                cur_addr <= req_addr;
                count    <= req_len;
            end
            if (issue_st || issue_ld) begin
                dm_ctrl  <= issue_st ? memwst : memwld;
                dm_addr  <= cur_addr;
                cur_addr <= cur_addr + 1'b1;
                count    <= count - 1'b1;
            end
            if (issue_st) dm_data_in <= wdata;
        end
    end

    dm_lsu_rdpipe #(.DEPTH(RD_LAT + 1)) u_rdpipe (
        .clk       (clk),
        .reset     (reset),
        .push      (issue_ld),
        .push_last (count == '0),
        .head_vld  (head_vld),
        .head_last (head_last),
        .empty     (pipe_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            rdata       <= '0;
        end else begin
            rdata_valid <= head_vld;
            rdata_last  <= head_vld & head_last;
            if (head_vld) rdata <= dm_data_out;
        end
    end

`ifdef DM_LSU_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_count <= '0;
            st_count <= '0;
        end else begin
            if (issue_ld && ld_count != 32'hFFFF_FFFF) ld_count <= ld_count + 1'b1;
            if (issue_st && st_count != 32'hFFFF_FFFF) st_count <= st_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: data_mem model, reference memory + cycle-indexed expectation tables, and per-cycle compare.
module tb_dm_lsu;
    import dm_pkg::*;
    localparam int RD_LAT = 1;
    localparam int LEN_W  = 8;
    localparam int NCYC   = 1024;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0, req_op = 1'b0;
    logic [0:31]       req_addr = '0;
    logic [0:LEN_W-1]  req_len = '0;
    logic              wdata_valid = 1'b0;
    logic [0:127]      wdata = '0;
    logic              req_ready, wdata_ready, rdata_valid, rdata_last, busy;
    logic [0:127]      rdata, dm_data_in, dm_data_out;
    logic [0:1]        dm_ctrl;
    logic [0:31]       dm_addr;
`ifdef DM_LSU_STATS_EN
    logic [0:31]       ld_count, st_count;
`endif

    dm_lsu #(.RD_LAT(RD_LAT), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata(wdata), .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last), .busy(busy),
`ifdef DM_LSU_STATS_EN
        .ld_count(ld_count), .st_count(st_count),
`endif
        .dm_ctrl(dm_ctrl), .dm_addr(dm_addr), .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] mem_default(input logic [31:0] a);
        return {96'hD0D0_0000_0000_0000_0000_0000, a};
    endfunction

    // data_mem model: writes on memwst, read data RD_LAT cycles after memwld.
    logic [127:0] dmem [logic [31:0]];
    logic [127:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (dm_ctrl == memwst) dmem[dm_addr] = dm_data_in;
        rd_pipe[0] <= (dm_ctrl == memwld) ? (dmem.exists(dm_addr) ? dmem[dm_addr] : mem_default(dm_addr)) : '0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign dm_data_out = rd_pipe[RD_LAT-1];

    // Reference memory and expected outputs per cycle.
    logic [127:0] ref_mem [logic [31:0]];
    logic [1:0]   exp_ctrl [NCYC];
    logic [31:0]  exp_addr [NCYC];
    logic [127:0] exp_din  [NCYC];
    bit           exp_rv   [NCYC];
    logic [127:0] exp_rd   [NCYC];
    bit           exp_last [NCYC];

    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;

    logic [31:0]  cmd_addr_log[$];
    int           cmd_cyc_log[$];
    logic [127:0] rv_data_log[$];
    bit           rv_last_log[$];
    int           rv_cyc_log[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] la(input int i);
        return (i < cmd_addr_log.size()) ? cmd_addr_log[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic int lc(input int i);
        return (i < cmd_cyc_log.size()) ? cmd_cyc_log[i] : -1000;
    endfunction
    function automatic logic [127:0] ld(input int i);
        return (i < rv_data_log.size()) ? rv_data_log[i] : 128'hx;
    endfunction

    always @(negedge clk) begin
        if (chk_en && reset && cyc < NCYC) begin
            check("dm_ctrl", 128'(dm_ctrl), 128'(exp_ctrl[cyc]));
            if (exp_ctrl[cyc] != memnop) check("dm_addr", 128'(dm_addr), 128'(exp_addr[cyc]));
            if (exp_ctrl[cyc] == memwst) check("dm_data_in", dm_data_in, exp_din[cyc]);
            check("rdata_valid", 128'(rdata_valid), 128'(exp_rv[cyc]));
            if (exp_rv[cyc]) begin
                check("rdata", rdata, exp_rd[cyc]);
                check("rdata_last", 128'(rdata_last), 128'(exp_last[cyc]));
            end
            if (dm_ctrl != memnop) begin
                cmd_addr_log.push_back(dm_addr);
                cmd_cyc_log.push_back(cyc);
            end
            if (rdata_valid) begin
                rv_data_log.push_back(rdata);
                rv_last_log.push_back(rdata_last);
                rv_cyc_log.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        cmd_addr_log.delete(); cmd_cyc_log.delete();
        rv_data_log.delete(); rv_last_log.delete(); rv_cyc_log.delete();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns acceptance cycle, positioned in the following cycle.
    task automatic start_req(input bit op, input logic [31:0] addr, input int len, output int a);
        int t = 0;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_len = LEN_W'(len);
        while (!req_ready && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (!req_ready) begin
            n_tests++; n_fail++;
            $display("FAIL req_accept: got timeout expected req_ready within 300 cycles");
        end
        a = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!req_ready && t < 300) begin
            @(posedge clk); #1; t++;
        end
        check("wait_idle", 128'(req_ready), 128'(1));
        idle_cycles(2);
    endtask

    task automatic schedule_load(input logic [31:0] addr, input int len, input int a);
        for (int i = 0; i <= len; i++) begin
            logic [31:0] wa;
            wa = addr + 32'(i);
            if (a + RD_LAT + 3 + i < NCYC) begin
                exp_ctrl[a+2+i] = memwld;
                exp_addr[a+2+i] = wa;
                exp_rv[a+RD_LAT+3+i]   = 1'b1;
                exp_rd[a+RD_LAT+3+i]   = ref_mem.exists(wa) ? ref_mem[wa] : mem_default(wa);
                exp_last[a+RD_LAT+3+i] = (i == len);
            end
        end
    endtask

    task automatic load_burst(input logic [31:0] addr, input int len, output int a);
        start_req(1'b0, addr, len, a);
        schedule_load(addr, len, a);
    endtask

    // vpat bit j = wdata_valid in the j-th cycle after acceptance (ones beyond bit 31).
    task automatic store_burst(input logic [31:0] addr, input int len, input logic [127:0] dbase,
                               input logic [31:0] vpat);
        int a, w, j;
        logic v;
        start_req(1'b1, addr, len, a);
        w = 0; j = 0;
        while (w <= len && j < 200) begin
            v = (j < 32) ? vpat[j] : 1'b1;
            wdata_valid = v;
            wdata = dbase + 128'(w);
            check("wdata_ready", 128'(wdata_ready), 128'(1));
            if (v && cyc + 1 < NCYC) begin
                exp_ctrl[cyc+1] = memwst;
                exp_addr[cyc+1] = addr + 32'(w);
                exp_din[cyc+1]  = dbase + 128'(w);
                ref_mem[addr + 32'(w)] = dbase + 128'(w);
                w++;
            end
            j++;
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        for (int i = 0; i < NCYC; i++) begin
            exp_ctrl[i] = memnop; exp_addr[i] = '0; exp_din[i] = '0;
            exp_rv[i] = 1'b0; exp_rd[i] = '0; exp_last[i] = 1'b0;
        end
        #1 reset = 1'b0;
        #2;
        check("rst_dm_ctrl", 128'(dm_ctrl), 128'(0));
        check("rst_dm_addr", 128'(dm_addr), 128'(0));
        check("rst_dm_data_in", dm_data_in, 128'(0));
        check("rst_rdata", rdata, 128'(0));
        check("rst_rdata_valid", 128'(rdata_valid), 128'(0));
        check("rst_rdata_last", 128'(rdata_last), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_wdata_ready", 128'(wdata_ready), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        chk_en = 1'b1;
        idle_cycles(1);

        // Continuous store burst of 9 words at address 1.
        clear_logs();
        store_burst(32'd1, 8, 128'h72, 32'hFFFF_FFFF);
        check("store_req_ready_back", 128'(req_ready), 128'(1));
        idle_cycles(2);
        check("store_cmd_count", 128'(cmd_addr_log.size()), 128'(9));
        check("store_first_addr", 128'(la(0)), 128'(1));
        check("store_last_addr", 128'(la(8)), 128'(9));
        check("store_consecutive", 128'(lc(8) - lc(0)), 128'(8));

        // Load it back, with an ignored request and stray wdata while busy.
        clear_logs();
        load_burst(32'd1, 8, a);
        req_valid = 1'b1; req_op = 1'b1; req_addr = 32'd99; wdata_valid = 1'b1; wdata = 128'hBAD;
        repeat (3) begin
            check("load_busy", 128'(busy), 128'(1));
            check("load_req_ready", 128'(req_ready), 128'(0));
            @(posedge clk); #1;
        end
        req_valid = 1'b0; wdata_valid = 1'b0;
        wait_idle();
        check("load_pulses", 128'(rv_data_log.size()), 128'(9));
        check("load_first_data", ld(0), 128'h72);
        check("load_last_data", ld(8), 128'h7A);
        check("load_last_flag", 128'(rv_last_log.size() == 9 ? rv_last_log[8] : 1'b0), 128'(1));
        check("load_last_count", 128'(rv_last_log.sum() with (int'(item))), 128'(1));
        check("load_first_latency", 128'((rv_cyc_log.size() > 0 ? rv_cyc_log[0] : -100) - a), 128'(4));
`ifdef DM_LSU_STATS_EN
        check("st_count", 128'(st_count), 128'(9));
        check("ld_count", 128'(ld_count), 128'(9));
`endif

        // Store with wdata_valid pattern 1,0,0,1,1.
        clear_logs();
        store_burst(32'd5, 2, 128'hA0, 32'h0000_0019);
        idle_cycles(2);
        check("gap_cmd_count", 128'(cmd_addr_log.size()), 128'(3));
        check("gap_addr0", 128'(la(0)), 128'(5));
        check("gap_addr1", 128'(la(1)), 128'(6));
        check("gap_addr2", 128'(la(2)), 128'(7));
        check("gap_spacing01", 128'(lc(1) - lc(0)), 128'(3));
        check("gap_spacing12", 128'(lc(2) - lc(1)), 128'(1));
        load_burst(32'd5, 2, a);
        wait_idle();

        // Address wrap.
        clear_logs();
        load_burst(32'hFFFF_FFFE, 2, a);
        wait_idle();
        check("wrap_addr0", 128'(la(0)), 128'(32'hFFFF_FFFE));
        check("wrap_addr1", 128'(la(1)), 128'(32'hFFFF_FFFF));
        check("wrap_addr2", 128'(la(2)), 128'(32'h0000_0000));

        // Reset in the middle of a load after three issues.
        clear_logs();
        load_burst(32'h40, 8, a);
        repeat (4) @(negedge clk);
        #1;
        check("rst_mid_issues", 128'(cmd_addr_log.size()), 128'(3));
        reset = 1'b0;
        for (int i = cyc; i < NCYC; i++) begin
            exp_ctrl[i] = memnop; exp_rv[i] = 1'b0;
        end
        #1;
        check("rst_mid_dm_ctrl", 128'(dm_ctrl), 128'(0));
        check("rst_mid_rdata_valid", 128'(rdata_valid), 128'(0));
        check("rst_mid_busy", 128'(busy), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        clear_logs();
        idle_cycles(8);
        check("rst_no_stale_rdata", 128'(rv_data_log.size()), 128'(0));
        load_burst(32'd1, 0, a);
        wait_idle();
        check("post_rst_pulses", 128'(rv_data_log.size()), 128'(1));
        check("post_rst_data", ld(0), 128'h72);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
